axis_alu_pipe: RTL and testbench

Registered, parametrised AXI-Stream arithmetic stage. It is the successor to the combinational byte-increment pass-through.
- Applies a selectable operation (ADD, SUB, XOR, AND, OR, PASS, INC) between each input beat and a per-packet operand.
- Carries tlast through the stage.
- Reports a carry/borrow flag and the beat index on tuser.
- A 2-entry skid buffer gives full throughput with registered ready and valid outputs; it sits between stream sources and sinks in the datapath.

---
 rtl/axis_alu_pipe.sv | 184 ++++++++++++++++++
 tb/tb_axis_alu_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_alu_pipe.sv
// axis_alu_pipe: registered AXI-Stream ALU stage with a per-packet operation
// and operand, carry/beat-index reporting on tuser, and a 2-entry skid buffer
// (main output register + skid register) for full throughput.
module axis_alu_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 12
) (
  input  logic                  aclk_i,
  input  logic                  arst_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  output logic                  s_axis_tready_o,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                  s_axis_tlast_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  m_axis_tvalid_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tlast_o,
  output logic [USER_WIDTH-1:0] m_axis_tuser_o,
  input  logic                  m_axis_tready_i
);

  localparam int unsigned IDX_W = USER_WIDTH - 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd6;

  typedef struct packed {
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic {
    PKT_IDLE,
    PKT_BODY
  } pkt_state_t;

  pkt_state_t            pkt_state;
  pkt_state_t            pkt_state_nxt;

  logic [2:0]            op_q;
  logic [DATA_WIDTH-1:0] operand_q;
  logic [IDX_W-1:0]      beat_idx_q;

  logic                  ready_q;
  logic                  main_valid;
  beat_t                 main_beat;
  logic                  skid_valid;
  beat_t                 skid_beat;

  logic                  accept_c;
  logic                  consume_c;
  logic                  skid_valid_nxt_c;

  logic [2:0]            op_eff_c;
  logic [DATA_WIDTH-1:0] operand_eff_c;
  logic [DATA_WIDTH:0]   sum_c;
  logic [DATA_WIDTH-1:0] result_c;
  logic                  carry_c;
  beat_t                 new_beat_c;

  assign accept_c  = s_axis_tvalid_i & ready_q;
  assign consume_c = main_valid & m_axis_tready_i;

  // First beat of a packet uses the live context; later beats the latched one.
  assign op_eff_c      = (pkt_state == PKT_IDLE) ? op_i      : op_q;
  assign operand_eff_c = (pkt_state == PKT_IDLE) ? operand_i : operand_q;

  // Packet tracking state register.
  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      pkt_state <= PKT_IDLE;
    end else begin
      pkt_state <= pkt_state_nxt;
    end
  end

  // Packet tracking next state: an accepted tlast closes the packet.
  always_comb begin
    pkt_state_nxt = pkt_state;
    if (accept_c) begin
      pkt_state_nxt = s_axis_tlast_i ? PKT_IDLE : PKT_BODY;
    end
  end

  // Latch op/operand on the first beat; track the saturating beat index.
  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      op_q       <= 3'd0;
      operand_q  <= '0;
      beat_idx_q <= '0;
    end else if (accept_c) begin
      if (pkt_state == PKT_IDLE) begin
        op_q      <= op_i;
        operand_q <= operand_i;
      end
      if (s_axis_tlast_i) begin
        beat_idx_q <= '0;
      end else if (!(&beat_idx_q)) begin
        beat_idx_q <= beat_idx_q + IDX_W'(1);
      end
    end
  end

  // Arithmetic/logic operation and carry (borrow for SUB).
  always_comb begin
    result_c = s_axis_tdata_i;
    carry_c  = 1'b0;
    sum_c    = (DATA_WIDTH+1)'(s_axis_tdata_i) + (DATA_WIDTH+1)'(operand_eff_c);
    case (op_eff_c)
      OP_ADD: begin
        result_c = sum_c[DATA_WIDTH-1:0];
        carry_c  = sum_c[DATA_WIDTH];
      end
      OP_SUB: begin
        result_c = s_axis_tdata_i - operand_eff_c;
        carry_c  = (s_axis_tdata_i < operand_eff_c);
      end
      OP_XOR:  result_c = s_axis_tdata_i ^ operand_eff_c;
      OP_AND:  result_c = s_axis_tdata_i & operand_eff_c;
      OP_OR:   result_c = s_axis_tdata_i | operand_eff_c;
      OP_INC: begin
        result_c = s_axis_tdata_i + DATA_WIDTH'(1);
        carry_c  = &s_axis_tdata_i;
      end
      default: result_c = s_axis_tdata_i;
    endcase
  end

  assign new_beat_c = '{last: s_axis_tlast_i,
                        user: {carry_c, beat_idx_q},
                        data: result_c};

  // Skid occupancy after this cycle; drives the registered ready.
  always_comb begin
    skid_valid_nxt_c = skid_valid;
    if (skid_valid) begin
      skid_valid_nxt_c = ~consume_c;
    end else begin
      skid_valid_nxt_c = accept_c & main_valid & ~consume_c;
    end
  end

  // Main/skid buffer: load main when free or draining, otherwise park in skid.
  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      main_valid <= 1'b0;
      main_beat  <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
      ready_q    <= 1'b0;
    end else begin
      if (skid_valid) begin
        if (consume_c) begin
          main_beat  <= skid_beat;
          skid_valid <= 1'b0;
        end
      end else if (accept_c) begin
        if (!main_valid || consume_c) begin
          main_beat  <= new_beat_c;
          main_valid <= 1'b1;
        end else begin
          skid_beat  <= new_beat_c;
          skid_valid <= 1'b1;
        end
      end else if (consume_c) begin
        main_valid <= 1'b0;
      end
      ready_q <= ~skid_valid_nxt_c;
    end
  end

  assign s_axis_tready_o = ready_q;
  assign m_axis_tvalid_o = main_valid;
  assign m_axis_tdata_o  = main_beat.data;
  assign m_axis_tlast_o  = main_beat.last;
  assign m_axis_tuser_o  = main_beat.user;

endmodule

// File: tb/tb_axis_alu_pipe.sv
// Self-checking bench for axis_alu_pipe: directed steps with a scoreboard
// queue filled on input acceptance and drained by an output monitor.
module tb_axis_alu_pipe;

  typedef struct packed {
    logic        last;
    logic [11:0] user;
    logic [7:0]  data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] op_in;
  logic [7:0] operand;
  logic       s_tready;
  logic [7:0] s_tdata;
  logic       s_tlast;
  logic       s_tvalid;
  logic       m_tvalid;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic [11:0] m_tuser;
  logic       m_tready;

  logic ready_mode;
  logic ready_fixed;
  logic rnd_ready;

  int checks;
  int failures;

  exp_t sb[$];
  logic [7:0]  obs_data[$];
  logic [11:0] obs_user[$];
  logic        obs_last[$];

  logic       m_in_pkt;
  logic [2:0] m_op;
  logic [7:0] m_b;
  int         m_idx;

  assign m_tready = ready_mode ? rnd_ready : ready_fixed;

  axis_alu_pipe #(.DATA_WIDTH(8), .USER_WIDTH(12)) dut (
    .aclk_i          (clk),
    .arst_i          (rst),
    .op_i            (op_in),
    .operand_i       (operand),
    .s_axis_tready_o (s_tready),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tlast_i  (s_tlast),
    .s_axis_tvalid_i (s_tvalid),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tdata_o  (m_tdata),
    .m_axis_tlast_o  (m_tlast),
    .m_axis_tuser_o  (m_tuser),
    .m_axis_tready_i (m_tready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in_pkt = 1'b0;
    m_idx    = 0;
    m_op     = 3'd0;
    m_b      = 8'd0;
  endtask

  // Reference result for one accepted beat.
  task automatic model_push(input logic [7:0] a, input logic l, input logic [2:0] op, input logic [7:0] b);
    logic [2:0] eop;
    logic [7:0] eb;
    int         r;
    logic       c;
    exp_t       e;
    eop = m_in_pkt ? m_op : op;
    eb  = m_in_pkt ? m_b : b;
    if (!m_in_pkt) begin
      m_op = op;
      m_b  = b;
    end
    c = 1'b0;
    case (eop)
      3'd0: begin r = int'(a) + int'(b == b ? eb : eb); c = (r > 255); end
      3'd1: begin r = int'(a) - int'(eb); c = (int'(a) < int'(eb)); end
      3'd2: r = int'(a ^ eb);
      3'd3: r = int'(a & eb);
      3'd4: r = int'(a | eb);
      3'd6: begin r = int'(a) + 1; c = (a == 8'hFF); end
      default: r = int'(a);
    endcase
    e.data = 8'(r & 255);
    e.last = l;
    e.user = {c, 11'(m_idx)};
    sb.push_back(e);
    if (l) begin
      m_in_pkt = 1'b0;
      m_idx    = 0;
    end else begin
      m_in_pkt = 1'b1;
      if (m_idx < 2047) m_idx++;
    end
  endtask

  // Drive one beat; entered and left at posedge+1.
  task automatic send(input logic [7:0] d, input logic l, input logic [2:0] op,
                      input logic [7:0] b, input int gap);
    logic acc;
    logic ok;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    s_tdata  = d;
    s_tlast  = l;
    op_in    = op;
    operand  = b;
    s_tvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      if (acc) model_push(d, l, op, b);
      #1;
      ok = acc;
    end
    s_tvalid = 1'b0;
    if (!ok) chk("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb.size() > 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_user.delete();
    obs_last.delete();
  endtask

  initial begin
    logic       tr[3];
    int         buffered;
    int         beats;
    int         len;
    logic [2:0] pop;
    logic [7:0] pb;
    logic       hold;
    exp_t       prev;
    exp_t       e;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    op_in = 3'd0;
    operand = 8'd0;
    s_tdata = 8'd0;
    s_tlast = 1'b0;
    s_tvalid = 1'b0;
    ready_mode = 1'b0;
    ready_fixed = 1'b0;
    rnd_ready = 1'b0;
    model_reset();

    fork
      forever begin
        @(posedge clk);
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
      end
      begin
        hold = 1'b0;
        prev = '0;
        forever begin
          @(negedge clk);
          if (rst) begin
            hold = 1'b0;
          end else begin
            if (hold) begin
              chk("hold_valid", 64'(m_tvalid), 64'd1);
              chk("hold_beat", 64'({m_tlast, m_tuser, m_tdata}), 64'(prev));
            end
            if (m_tvalid && m_tready) begin
              if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(m_tdata), 64'hDEAD);
              end else begin
                e = sb.pop_front();
                chk("tdata", 64'(m_tdata), 64'(e.data));
                chk("tlast", 64'(m_tlast), 64'(e.last));
                chk("tuser", 64'(m_tuser), 64'(e.user));
              end
              obs_data.push_back(m_tdata);
              obs_user.push_back(m_tuser);
              obs_last.push_back(m_tlast);
            end
            hold = m_tvalid && !m_tready;
            prev = '{last: m_tlast, user: m_tuser, data: m_tdata};
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tuser", 64'(m_tuser), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("tready_before_edge", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    chk("tready_after_edge", 64'(s_tready), 64'd1);

    // INC single beat
    ready_fixed = 1'b1;
    send(8'h41, 1'b1, 3'd6, 8'h00, 0);
    chk("inc_tvalid", 64'(m_tvalid), 64'd1);
    chk("inc_tdata", 64'(m_tdata), 64'h42);
    chk("inc_tlast", 64'(m_tlast), 64'd1);
    chk("inc_tuser", 64'(m_tuser), 64'h000);
    @(posedge clk);
    #1;
    chk("inc_tvalid_drop", 64'(m_tvalid), 64'd0);

    // ADD packet, op changes mid-packet are ignored
    clear_obs();
    send(8'hF8, 1'b0, 3'd0, 8'h10, 0);
    send(8'h01, 1'b0, 3'd2, 8'h10, 0);
    send(8'h02, 1'b0, 3'd2, 8'h10, 0);
    send(8'h03, 1'b1, 3'd2, 8'h10, 0);
    drain();
    chk("add_count", 64'(obs_data.size()), 64'd4);
    if (obs_data.size() == 4) begin
      chk("add_d0", 64'(obs_data[0]), 64'h08);
      chk("add_d1", 64'(obs_data[1]), 64'h11);
      chk("add_d2", 64'(obs_data[2]), 64'h12);
      chk("add_d3", 64'(obs_data[3]), 64'h13);
      chk("add_u0", 64'(obs_user[0]), 64'h800);
      chk("add_u1", 64'(obs_user[1]), 64'h001);
      chk("add_u3", 64'(obs_user[3]), 64'h003);
      chk("add_l2", 64'(obs_last[2]), 64'd0);
      chk("add_l3", 64'(obs_last[3]), 64'd1);
    end

    // SUB with borrow
    clear_obs();
    send(8'h03, 1'b0, 3'd1, 8'h05, 0);
    send(8'h05, 1'b1, 3'd1, 8'h05, 0);
    drain();
    chk("sub_count", 64'(obs_data.size()), 64'd2);
    if (obs_data.size() == 2) begin
      chk("sub_d0", 64'(obs_data[0]), 64'hFE);
      chk("sub_u0", 64'(obs_user[0]), 64'h800);
      chk("sub_d1", 64'(obs_data[1]), 64'h00);
      chk("sub_u1", 64'(obs_user[1]), 64'h001);
    end

    // Back-pressure: 3 stall cycles during a continuous stream
    clear_obs();
    buffered = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(8'(8'h20 + i), (i == 7), 3'd5, 8'h00, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        ready_fixed = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          tr[k] = s_tready;
          if (k == 2) buffered = sb.size();
          if (k < 2) begin
            @(posedge clk);
            #1;
          end
        end
        @(posedge clk);
        #1;
        ready_fixed = 1'b1;
      end
    join
    chk("bp_ready_c1", 64'(tr[0]), 64'd1);
    chk("bp_ready_c2", 64'(tr[1]), 64'd0);
    chk("bp_ready_c3", 64'(tr[2]), 64'd0);
    chk("bp_buffered", 64'(buffered), 64'd2);
    drain();
    chk("bp_count", 64'(obs_data.size()), 64'd8);
    for (int i = 0; i < 8 && i < obs_data.size(); i++)
      chk("bp_order", 64'(obs_data[i]), 64'(8'h20 + i));

    // Random valid/ready, random op per packet, random mid-packet op noise
    ready_mode = 1'b1;
    beats = 0;
    while (beats < 1000) begin
      pop = 3'($urandom_range(0, 7));
      pb  = 8'($urandom);
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        send(8'($urandom), (j == len - 1),
             (j == 0) ? pop : 3'($urandom_range(0, 7)),
             (j == 0) ? pb : 8'($urandom), $urandom_range(0, 2));
        beats++;
      end
    end
    drain();
    ready_mode = 1'b0;
    ready_fixed = 1'b1;

    // Beat index saturation on a long packet
    clear_obs();
    for (int i = 0; i < 2050; i++) send(8'(i), (i == 2049), 3'd5, 8'h00, 0);
    drain();
    chk("sat_count", 64'(obs_user.size()), 64'd2050);
    if (obs_user.size() == 2050) begin
      chk("sat_idx_2046", 64'(obs_user[2046]), 64'h7FE);
      chk("sat_idx_2047", 64'(obs_user[2047]), 64'h7FF);
      chk("sat_idx_2049", 64'(obs_user[2049]), 64'h7FF);
    end

    // Reset mid-packet with both buffers full
    ready_fixed = 1'b0;
    send(8'h10, 1'b0, 3'd0, 8'h01, 0);
    send(8'h11, 1'b0, 3'd0, 8'h01, 0);
    chk("pre_rst_tready", 64'(s_tready), 64'd0);
    chk("pre_rst_tvalid", 64'(m_tvalid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_tready", 64'(s_tready), 64'd0);
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ready_fixed = 1'b1;
    clear_obs();
    send(8'h7F, 1'b1, 3'd6, 8'h33, 0);
    drain();
    chk("postrst_count", 64'(obs_data.size()), 64'd1);
    if (obs_data.size() == 1) begin
      chk("postrst_data", 64'(obs_data[0]), 64'h80);
      chk("postrst_user", 64'(obs_user[0]), 64'h000);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
